alu_issue_ctrl: RTL and testbench

//   Shares one combinational alu instance between NUM_REQ requesters (warp lanes / issue slots).

---
 rtl/warp_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/alu_issue_ctrl.sv | 170 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/warp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : warp_pkg
// Description : Shared types and helpers for the warp ALU issue path.
// Revision    : 1.0 - initial release
// ============================================================================
package warp_pkg;

   localparam int DATA_WIDTH  = 32;
   localparam int NUM_ALU_REQ = 4;
   localparam int OPC_WIDTH   = 3;

   typedef enum logic [OPC_WIDTH-1:0] {
      OP_ADD  = 3'd0,
      OP_MUL  = 3'd1,
      OP_FMA  = 3'd2,
      OP_MAX  = 3'd3,
      OP_RELU = 3'd4
   } alu_opcode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } ctrl_state_e;

   // Opcodes the ALU actually implements; anything else is reported as illegal.
   function automatic logic is_legal_op(input alu_opcode_e op);
      case (op)
         OP_ADD, OP_MUL, OP_FMA, OP_MAX, OP_RELU: return 1'b1;
         default:                                  return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Searches from the slot after the last
//               winner; pointer advances only when a grant is taken.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter  int N     = 4,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     i_req,
   input  logic             i_advance,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_grant_idx,
   output logic             o_any
);

   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_cand;

   // Priority search starting at r_ptr+1, wrapping modulo N.
   always_comb begin
      o_any       = 1'b0;
      o_grant_idx = '0;
      o_grant     = '0;
      w_cand      = '0;
      for (int k = 1; k <= N; k++) begin
         w_cand = IDX_W'((int'(r_ptr) + k) % N);
         if (!o_any && i_req[w_cand]) begin
            o_any       = 1'b1;
            o_grant_idx = w_cand;
         end
      end
      o_grant[o_grant_idx] = o_any;
   end

   // Last-winner pointer; reset to N-1 so requester 0 is searched first.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= IDX_W'(N - 1);
      end else if (i_advance && o_any) begin
         r_ptr <= o_grant_idx;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Shares one combinational ALU between NUM_REQ requesters.
//               IDLE arbitrates, EXEC drives the ALU, RESP holds the tagged
//               result until consumed. Per-requester saturating overflow
//               counters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
   import warp_pkg::*;
#(
   parameter  int DATA_WIDTH = warp_pkg::DATA_WIDTH,
   parameter  int NUM_REQ    = NUM_ALU_REQ,
   parameter  int TAG_WIDTH  = 4,
   parameter  int CNT_WIDTH  = 8,
   localparam int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             i_req_valid,
   output logic [NUM_REQ-1:0]             o_req_ready,
   input  logic [NUM_REQ*OPC_WIDTH-1:0]   i_req_opcode,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_op1,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_op2,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_op3,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]   i_req_tag,
   output logic [OPC_WIDTH-1:0]           o_alu_opcode,
   output logic [DATA_WIDTH-1:0]          o_alu_operand1,
   output logic [DATA_WIDTH-1:0]          o_alu_operand2,
   output logic [DATA_WIDTH-1:0]          o_alu_operand3,
   input  logic [DATA_WIDTH-1:0]          i_alu_result,
   input  logic                           i_alu_overflow,
   input  logic                           i_alu_ready,
   output logic                           o_rsp_valid,
   input  logic                           i_rsp_ready,
   output logic [ID_W-1:0]                o_rsp_id,
   output logic [TAG_WIDTH-1:0]           o_rsp_tag,
   output logic [DATA_WIDTH-1:0]          o_rsp_result,
   output logic                           o_rsp_overflow,
   output logic                           o_rsp_illegal,
   output logic [NUM_REQ*CNT_WIDTH-1:0]   o_ovf_count
);

   ctrl_state_e             r_state;
   ctrl_state_e             w_state_next;

   logic                    w_idle;
   logic                    w_any;
   logic [NUM_REQ-1:0]      w_grant;
   logic [ID_W-1:0]         w_grant_idx;
   logic                    w_capture;
   logic                    w_legal;

   logic [OPC_WIDTH-1:0]    r_opcode;
   logic [DATA_WIDTH-1:0]   r_op1;
   logic [DATA_WIDTH-1:0]   r_op2;
   logic [DATA_WIDTH-1:0]   r_op3;
   logic [TAG_WIDTH-1:0]    r_tag;
   logic [ID_W-1:0]         r_id;

   logic [ID_W-1:0]         r_rsp_id;
   logic [TAG_WIDTH-1:0]    r_rsp_tag;
   logic [DATA_WIDTH-1:0]   r_rsp_result;
   logic                    r_rsp_overflow;
   logic                    r_rsp_illegal;
   logic [CNT_WIDTH-1:0]    r_ovf_cnt [NUM_REQ];

   assign w_idle    = (r_state == IDLE);
   assign w_capture = (r_state == EXEC) && i_alu_ready;
   assign w_legal   = is_legal_op(alu_opcode_e'(r_opcode));

   // Requests are masked outside IDLE, so the grant doubles as req_ready.
   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk         (clk),
      .rst         (rst),
      .i_req       (i_req_valid & {NUM_REQ{w_idle}}),
      .i_advance   (w_idle),
      .o_grant     (w_grant),
      .o_grant_idx (w_grant_idx),
      .o_any       (w_any)
   );

   assign o_req_ready = w_grant;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: grant -> ALU handshake -> response handshake.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_any)       w_state_next = EXEC;
         EXEC:    if (i_alu_ready) w_state_next = RESP;
         RESP:    if (i_rsp_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Latch the granted request; these registers drive the ALU and hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_opcode <= '0;
         r_op1    <= '0;
         r_op2    <= '0;
         r_op3    <= '0;
         r_tag    <= '0;
         r_id     <= '0;
      end else if (w_idle && w_any) begin
         r_opcode <= i_req_opcode[w_grant_idx*OPC_WIDTH +: OPC_WIDTH];
         r_op1    <= i_req_op1[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
         r_op2    <= i_req_op2[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
         r_op3    <= i_req_op3[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
         r_tag    <= i_req_tag[w_grant_idx*TAG_WIDTH +: TAG_WIDTH];
         r_id     <= w_grant_idx;
      end
   end

   assign o_alu_opcode   = r_opcode;
   assign o_alu_operand1 = r_op1;
   assign o_alu_operand2 = r_op2;
   assign o_alu_operand3 = r_op3;

   // Capture the ALU outcome on the EXEC->RESP transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_id       <= '0;
         r_rsp_tag      <= '0;
         r_rsp_result   <= '0;
         r_rsp_overflow <= 1'b0;
         r_rsp_illegal  <= 1'b0;
      end else if (w_capture) begin
         r_rsp_id       <= r_id;
         r_rsp_tag      <= r_tag;
         r_rsp_result   <= i_alu_result;
         r_rsp_overflow <= i_alu_overflow;
         r_rsp_illegal  <= !w_legal;
      end
   end

   assign o_rsp_valid    = (r_state == RESP);
   assign o_rsp_id       = r_rsp_id;
   assign o_rsp_tag      = r_rsp_tag;
   assign o_rsp_result   = r_rsp_result;
   assign o_rsp_overflow = r_rsp_overflow;
   assign o_rsp_illegal  = r_rsp_illegal;

   // Saturating overflow counters; illegal ops never count.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_ovf_cnt[i] <= '0;
         end
      end else if (w_capture && i_alu_overflow && w_legal && (r_ovf_cnt[r_id] != '1)) begin
         r_ovf_cnt[r_id] <= r_ovf_cnt[r_id] + CNT_WIDTH'(1);
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
      assign o_ovf_count[g*CNT_WIDTH +: CNT_WIDTH] = r_ovf_cnt[g];
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Directed self-checking bench for alu_issue_ctrl with a
//               behavioural ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;
   import warp_pkg::*;

   localparam int DW = 32;
   localparam int NR = 4;
   localparam int TW = 4;
   localparam int CW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*3-1:0]   req_opc;
   logic [NR*DW-1:0]  req_op1, req_op2, req_op3;
   logic [NR*TW-1:0]  req_tag;
   logic [2:0]        alu_opcode;
   logic [DW-1:0]     alu_op1, alu_op2, alu_op3;
   logic [DW-1:0]     alu_result;
   logic              alu_overflow;
   logic              alu_ready;
   logic              rsp_valid, rsp_ready;
   logic [1:0]        rsp_id;
   logic [TW-1:0]     rsp_tag;
   logic [DW-1:0]     rsp_result;
   logic              rsp_overflow, rsp_illegal;
   logic [NR*CW-1:0]  ovf_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready),
      .i_req_opcode   (req_opc),
      .i_req_op1      (req_op1),
      .i_req_op2      (req_op2),
      .i_req_op3      (req_op3),
      .i_req_tag      (req_tag),
      .o_alu_opcode   (alu_opcode),
      .o_alu_operand1 (alu_op1),
      .o_alu_operand2 (alu_op2),
      .o_alu_operand3 (alu_op3),
      .i_alu_result   (alu_result),
      .i_alu_overflow (alu_overflow),
      .i_alu_ready    (alu_ready),
      .o_rsp_valid    (rsp_valid),
      .i_rsp_ready    (rsp_ready),
      .o_rsp_id       (rsp_id),
      .o_rsp_tag      (rsp_tag),
      .o_rsp_result   (rsp_result),
      .o_rsp_overflow (rsp_overflow),
      .o_rsp_illegal  (rsp_illegal),
      .o_ovf_count    (ovf_count)
   );

   // Behavioural ALU: signed arithmetic, overflow when the exact result does not fit.
   longint m_a, m_b, m_c, m_full;
   always_comb begin
      m_a    = longint'($signed(alu_op1));
      m_b    = longint'($signed(alu_op2));
      m_c    = longint'($signed(alu_op3));
      m_full = 0;
      case (alu_opcode)
         OP_ADD:  m_full = m_a + m_b;
         OP_MUL:  m_full = m_a * m_b;
         OP_FMA:  m_full = m_a * m_b + m_c;
         OP_MAX:  m_full = (m_a > m_b) ? m_a : m_b;
         OP_RELU: m_full = (m_a < 0) ? 0 : m_a;
         default: m_full = 0;
      endcase
      alu_result   = m_full[31:0];
      alu_overflow = (m_full != longint'($signed(m_full[31:0])));
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_req(input int idx, input logic [2:0] opc, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c, input logic [3:0] tag);
      req_opc[idx*3 +: 3]   = opc;
      req_op1[idx*DW +: DW] = a;
      req_op2[idx*DW +: DW] = b;
      req_op3[idx*DW +: DW] = c;
      req_tag[idx*TW +: TW] = tag;
      req_valid[idx]        = 1'b1;
   endtask

   // One isolated operation from an IDLE cycle with rsp_ready=1; ends in the next IDLE cycle.
   task automatic op_single(input int idx, input logic [2:0] opc, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] c, input logic [3:0] tag,
                            input logic [31:0] exp_res, input logic exp_ovf, input logic exp_ill);
      logic [3:0] exp_rdy;
      exp_rdy = 4'b0001 << idx;
      set_req(idx, opc, a, b, c, tag);
      settle();
      chk("grant", 64'(req_ready), 64'(exp_rdy));
      cyc();
      req_valid[idx] = 1'b0;
      settle();
      chk("exec_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("exec_alu_op1", 64'(alu_op1), 64'(a));
      cyc();
      settle();
      chk("rsp_valid", 64'(rsp_valid), 64'(1));
      chk("rsp_result", 64'(rsp_result), 64'(exp_res));
      chk("rsp_overflow", 64'(rsp_overflow), 64'(exp_ovf));
      chk("rsp_illegal", 64'(rsp_illegal), 64'(exp_ill));
      chk("rsp_id", 64'(rsp_id), 64'(idx));
      chk("rsp_tag", 64'(rsp_tag), 64'(tag));
      cyc();
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_opc   = '0;
      req_op1   = '0;
      req_op2   = '0;
      req_op3   = '0;
      req_tag   = '0;
      alu_ready = 1'b1;
      rsp_ready = 1'b1;
      repeat (3) cyc();
      settle();

      // Reset state
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_result", 64'(rsp_result), 64'(0));
      chk("rst_alu_opcode", 64'(alu_opcode), 64'(0));
      chk("rst_alu_op1", 64'(alu_op1), 64'(0));
      chk("rst_ovf_count", 64'(ovf_count), 64'(0));
      rst = 1'b0;

      // Basic operations
      op_single(0, OP_ADD, 32'd5, 32'd7, 32'd0, 4'hA, 32'd12, 1'b0, 1'b0);
      op_single(2, OP_MUL, 32'h4000_0000, 32'd4, 32'd0, 4'h2, 32'd0, 1'b1, 1'b0);
      chk("ovf_cnt_after_mul", 64'(ovf_count), 64'h0001_0000);
      op_single(1, OP_FMA, 32'd3, 32'd4, 32'hFFFF_FFEC, 4'h1, 32'hFFFF_FFF8, 1'b0, 1'b0);
      op_single(3, OP_MAX, 32'hFFFF_FFFB, 32'd3, 32'd0, 4'h3, 32'd3, 1'b0, 1'b0);
      op_single(0, OP_RELU, 32'hFFFF_FFF7, 32'd0, 32'd0, 4'h4, 32'd0, 1'b0, 1'b0);
      op_single(0, OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 4'h5, 32'h8000_0000, 1'b1, 1'b0);
      chk("ovf_cnt_after_add", 64'(ovf_count), 64'h0001_0001);

      // Backpressure: last grant was requester 0
      rsp_ready = 1'b0;
      set_req(1, OP_ADD, 32'd1, 32'd2, 32'd0, 4'h6);
      settle();
      chk("bp_grant1", 64'(req_ready), 64'b0010);
      cyc();
      req_valid[1] = 1'b0;
      set_req(2, OP_ADD, 32'd10, 32'd20, 32'd0, 4'h7);
      set_req(3, OP_ADD, 32'd30, 32'd40, 32'd0, 4'h8);
      settle();
      chk("bp_exec_ready", 64'(req_ready), 64'(0));
      cyc();
      settle();
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_rsp_result", 64'(rsp_result), 64'd3);
      for (int i = 0; i < 10; i++) begin
         cyc();
         settle();
         chk("bp_hold_valid", 64'(rsp_valid), 64'(1));
         chk("bp_hold_result", 64'(rsp_result), 64'd3);
         chk("bp_hold_id", 64'(rsp_id), 64'd1);
         chk("bp_hold_tag", 64'(rsp_tag), 64'h6);
         chk("bp_hold_ready", 64'(req_ready), 64'(0));
      end
      rsp_ready = 1'b1;
      settle();
      chk("bp_release_ready", 64'(req_ready), 64'(0));
      cyc();
      settle();
      chk("bp_next_grant", 64'(req_ready), 64'b0100);
      chk("bp_idle_valid", 64'(rsp_valid), 64'(0));
      cyc();
      req_valid[2] = 1'b0;
      cyc();
      settle();
      chk("bp_r2_result", 64'(rsp_result), 64'd30);
      chk("bp_r2_id", 64'(rsp_id), 64'd2);
      cyc();
      settle();
      chk("bp_grant3", 64'(req_ready), 64'b1000);
      cyc();
      req_valid[3] = 1'b0;
      cyc();
      settle();
      chk("bp_r3_result", 64'(rsp_result), 64'd70);
      chk("bp_r3_id", 64'(rsp_id), 64'd3);
      cyc();

      // Illegal opcode
      op_single(1, 3'd7, 32'h7FFF_FFFF, 32'd6, 32'd0, 4'h9, 32'd0, 1'b0, 1'b1);
      chk("ill_ovf_count", 64'(ovf_count), 64'h0001_0001);

      // Counter saturation on requester 3
      for (int i = 0; i < 300; i++) begin
         op_single(3, OP_MUL, 32'h4000_0000, 32'd4, 32'd0, 4'h0, 32'd0, 1'b1, 1'b0);
         if (i == 253) chk("sat_254", 64'(ovf_count[31:24]), 64'd254);
         if (i == 254) chk("sat_255", 64'(ovf_count[31:24]), 64'd255);
      end
      chk("sat_final", 64'(ovf_count), 64'hFF01_0001);

      // Reset while in EXEC with the ALU stalled
      alu_ready = 1'b0;
      set_req(1, OP_ADD, 32'd1, 32'd1, 32'd0, 4'h3);
      settle();
      chk("rstx_grant", 64'(req_ready), 64'b0010);
      cyc();
      req_valid[1] = 1'b0;
      settle();
      chk("rstx_exec_valid", 64'(rsp_valid), 64'(0));
      cyc();
      settle();
      chk("rstx_stall_valid", 64'(rsp_valid), 64'(0));
      chk("rstx_stall_op1", 64'(alu_op1), 64'd1);
      rst = 1'b1;
      cyc();
      rst       = 1'b0;
      alu_ready = 1'b1;
      settle();
      chk("rstx_valid", 64'(rsp_valid), 64'(0));
      chk("rstx_ovf_count", 64'(ovf_count), 64'(0));
      chk("rstx_alu_op1", 64'(alu_op1), 64'(0));
      for (int i = 0; i < 5; i++) begin
         cyc();
         settle();
         chk("rstx_no_rsp", 64'(rsp_valid), 64'(0));
      end

      // Fairness: all requesters continuously valid, rotation 0,1,2,3,0,1
      for (int r = 0; r < NR; r++) set_req(r, OP_ADD, 32'(r), 32'd100, 32'd0, 4'(r));
      for (int k = 0; k < 6; k++) begin
         settle();
         chk("fair_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
         chk("fair_idle_valid", 64'(rsp_valid), 64'(0));
         cyc();
         settle();
         chk("fair_exec_valid", 64'(rsp_valid), 64'(0));
         cyc();
         settle();
         chk("fair_rsp_valid", 64'(rsp_valid), 64'(1));
         chk("fair_rsp_id", 64'(rsp_id), 64'(k % 4));
         chk("fair_rsp_result", 64'(rsp_result), 64'(100 + (k % 4)));
         if (k == 5) req_valid = '0;
         cyc();
      end
      repeat (2) cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
